game_flow_controller: RTL and testbench



---
 rtl/game_flow_controller_if.sv | 43 ++++
 rtl/game_flow_controller.sv | 212 +++++++++++++++++++++
 tb/tb_game_flow_controller.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_controller_if.sv
// Signal bundle between the Frogger game flow sequencer and its neighbours:
// debounced start chord, collision and level-up events in; gating, freeze,
// respawn, life LEDs and debug state out.
interface game_flow_controller_if;
    logic       i_Start;
    logic       i_Has_Collided;
    logic       i_Level_Up;
    logic       o_Game_Active;
    logic       o_Obstacles_Freeze;
    logic       o_Frog_Respawn;
    logic [3:0] o_Lives;
    logic       o_Game_Over;
    logic       o_Invulnerable;
    logic [2:0] o_State;

    // Side that produces the game events and consumes the sequencing outputs
    modport master (
        output i_Start,
        output i_Has_Collided,
        output i_Level_Up,
        input  o_Game_Active,
        input  o_Obstacles_Freeze,
        input  o_Frog_Respawn,
        input  o_Lives,
        input  o_Game_Over,
        input  o_Invulnerable,
        input  o_State
    );

    // The sequencer itself
    modport slave (
        input  i_Start,
        input  i_Has_Collided,
        input  i_Level_Up,
        output o_Game_Active,
        output o_Obstacles_Freeze,
        output o_Frog_Respawn,
        output o_Lives,
        output o_Game_Over,
        output o_Invulnerable,
        output o_State
    );
endinterface

// File: rtl/game_flow_controller.sv
// Frogger game life-cycle sequencer: idle, start arming, play, hit freeze,
// respawn and game over, plus the thermometer life counter.  It only gates
// and pulses the neighbouring datapaths; positions are computed elsewhere.
//
// Optional feature macro: GAME_FLOW_INVULN_EN
//   When defined, every return to play after a respawn starts a window of
//   C_INVULN_CYCLES cycles during which collisions are ignored.  When not
//   defined, o_Invulnerable is tied low and no immunity counter exists.
module game_flow_controller #(
    parameter logic [3:0] C_LIVES_INI     = 4'b1111,
    parameter int         C_HIT_CYCLES    = 12_500_000,
    parameter int         C_OVER_CYCLES   = 50_000_000,
    parameter int         C_INVULN_CYCLES = 25_000_000
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    game_flow_controller_if.slave  bus
);

    // Shared down-counter sized for the largest duration parameter
    localparam int C_MAX_HO    = (C_HIT_CYCLES > C_OVER_CYCLES) ? C_HIT_CYCLES : C_OVER_CYCLES;
    localparam int C_TIMER_MAX = (C_MAX_HO > C_INVULN_CYCLES) ? C_MAX_HO : C_INVULN_CYCLES;
    localparam int C_TIMER_W   = (C_TIMER_MAX > 1) ? $clog2(C_TIMER_MAX) : 1;

    localparam logic [C_TIMER_W-1:0] C_TIMER_ZERO = C_TIMER_W'(0);
    localparam logic [C_TIMER_W-1:0] C_TIMER_ONE  = C_TIMER_W'(1);
    localparam logic [C_TIMER_W-1:0] C_HIT_LOAD   = C_TIMER_W'(C_HIT_CYCLES - 1);
    localparam logic [C_TIMER_W-1:0] C_OVER_LOAD  = C_TIMER_W'(C_OVER_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_HIT       = 3'd3,
        ST_RESPAWN   = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [3:0]             lives_r;
    logic [3:0]             lives_nxt_s;
    logic [C_TIMER_W-1:0]   timer_r;
    logic [C_TIMER_W-1:0]   timer_nxt_s;
    logic                   game_active_r;
    logic                   freeze_r;
    logic                   respawn_r;
    logic                   game_over_r;
    logic                   shield_s;
    logic                   hit_s;

    // Obstacles stand still whenever the frog is not actually playing or respawning
    function automatic logic freeze_of(input state_t st);
        logic f;
        case (st)
            ST_IDLE:      f = 1'b1;
            ST_ARM:       f = 1'b1;
            ST_HIT:       f = 1'b1;
            ST_GAME_OVER: f = 1'b1;
            ST_RUNNING:   f = 1'b0;
            ST_RESPAWN:   f = 1'b0;
            default:      f = 1'b1;
        endcase
        return f;
    endfunction

`ifdef GAME_FLOW_INVULN_EN
    localparam int C_INV_W = (C_INVULN_CYCLES > 0) ? $clog2(C_INVULN_CYCLES + 1) : 1;
    localparam logic [C_INV_W-1:0] C_INV_ZERO = C_INV_W'(0);
    localparam logic [C_INV_W-1:0] C_INV_ONE  = C_INV_W'(1);
    localparam logic [C_INV_W-1:0] C_INV_LOAD = C_INV_W'(C_INVULN_CYCLES);

    logic [C_INV_W-1:0] inv_cnt_r;
    logic [C_INV_W-1:0] inv_cnt_nxt_s;
    logic               invuln_r;

    assign shield_s           = invuln_r;
    assign bus.o_Invulnerable = invuln_r;

    // Immunity window: armed on each return to play, counts down while playing, cleared elsewhere
    always_comb begin
        inv_cnt_nxt_s = C_INV_ZERO;
        if ((state_r == ST_RESPAWN) && (state_nxt_s == ST_RUNNING)) begin
            inv_cnt_nxt_s = C_INV_LOAD;
        end else if ((state_r == ST_RUNNING) && (state_nxt_s == ST_RUNNING)) begin
            if (inv_cnt_r != C_INV_ZERO) begin
                inv_cnt_nxt_s = inv_cnt_r - C_INV_ONE;
            end else begin
                inv_cnt_nxt_s = C_INV_ZERO;
            end
        end else begin
            inv_cnt_nxt_s = C_INV_ZERO;
        end
    end

    // Immunity counter and its registered flag
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            inv_cnt_r <= C_INV_ZERO;
            invuln_r  <= 1'b0;
        end else begin
            inv_cnt_r <= inv_cnt_nxt_s;
            invuln_r  <= (inv_cnt_nxt_s != C_INV_ZERO);
        end
    end
`else
    assign shield_s           = 1'b0;
    assign bus.o_Invulnerable = 1'b0;
`endif

    // A collision only counts while playing and not shielded
    always_comb begin
        hit_s = 1'b0;
        if ((state_r == ST_RUNNING) && bus.i_Has_Collided && !shield_s) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Next-state, life and timer decisions; inputs outside their states are ignored
    always_comb begin
        state_nxt_s = state_r;
        lives_nxt_s = lives_r;
        timer_nxt_s = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_Start) begin
                    lives_nxt_s = C_LIVES_INI;
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                // Wait for the start chord to be released so it is not read as frog moves
                if (!bus.i_Start) begin
                    state_nxt_s = ST_RESPAWN;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_RUNNING: begin
                if (hit_s) begin
                    lives_nxt_s = {1'b0, lives_r[3:1]};
                    if (lives_r == 4'b0001) begin
                        state_nxt_s = ST_GAME_OVER;
                        timer_nxt_s = C_OVER_LOAD;
                    end else begin
                        state_nxt_s = ST_HIT;
                        timer_nxt_s = C_HIT_LOAD;
                    end
                end else if (bus.i_Level_Up) begin
                    // Shifting a one in from the bottom saturates at all-ones by itself
                    lives_nxt_s = {lives_r[2:0], 1'b1};
                    state_nxt_s = ST_RUNNING;
                end else begin
                    state_nxt_s = ST_RUNNING;
                end
            end
            ST_HIT: begin
                if (timer_r == C_TIMER_ZERO) begin
                    state_nxt_s = ST_RESPAWN;
                end else begin
                    timer_nxt_s = timer_r - C_TIMER_ONE;
                end
            end
            ST_RESPAWN: begin
                state_nxt_s = ST_RUNNING;
            end
            ST_GAME_OVER: begin
                if (timer_r == C_TIMER_ZERO) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    timer_nxt_s = timer_r - C_TIMER_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they settle with it
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_r       <= ST_IDLE;
            lives_r       <= C_LIVES_INI;
            timer_r       <= C_TIMER_ZERO;
            game_active_r <= 1'b0;
            freeze_r      <= 1'b1;
            respawn_r     <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            lives_r       <= lives_nxt_s;
            timer_r       <= timer_nxt_s;
            game_active_r <= (state_nxt_s == ST_RUNNING);
            freeze_r      <= freeze_of(state_nxt_s);
            respawn_r     <= (state_nxt_s == ST_RESPAWN);
            game_over_r   <= (state_nxt_s == ST_GAME_OVER);
        end
    end

    assign bus.o_Game_Active      = game_active_r;
    assign bus.o_Obstacles_Freeze = freeze_r;
    assign bus.o_Frog_Respawn     = respawn_r;
    assign bus.o_Lives            = lives_r;
    assign bus.o_Game_Over        = game_over_r;
    assign bus.o_State            = state_r;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: a life-count based model is
// compared against every output on each falling clock edge, and directed
// scenarios carry hand-computed expectations.
module tb_game_flow_controller;

    localparam int HIT  = 4;
    localparam int OVER = 6;
    localparam int INV  = 3;
`ifdef GAME_FLOW_INVULN_EN
    localparam int SHIELD_LOAD = INV;
    localparam int ACCEPT_N    = INV + 1;
`else
    localparam int SHIELD_LOAD = 0;
    localparam int ACCEPT_N    = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    game_flow_controller_if gf_if();

    game_flow_controller #(
        .C_LIVES_INI     (4'b1111),
        .C_HIT_CYCLES    (HIT),
        .C_OVER_CYCLES   (OVER),
        .C_INVULN_CYCLES (INV)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (gf_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int therm(input int n);
        case (n)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            3:       return 7;
            default: return 15;
        endcase
    endfunction

    // Model: mode follows the published state numbering, lives kept as a count,
    // wait = cycles left in the current timed phase, shield = immune cycles left.
    int m_mode, m_lives, m_wait, m_shield;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode   <= 0;
            m_lives  <= 4;
            m_wait   <= 0;
            m_shield <= 0;
        end else begin
            case (m_mode)
                0: if (gf_if.i_Start) begin m_lives <= 4; m_mode <= 1; end
                1: if (!gf_if.i_Start) m_mode <= 4;
                2: begin
                    if (gf_if.i_Has_Collided && m_shield == 0) begin
                        m_lives  <= m_lives - 1;
                        m_shield <= 0;
                        if (m_lives == 1) begin m_mode <= 5; m_wait <= OVER; end
                        else begin m_mode <= 3; m_wait <= HIT; end
                    end else begin
                        if (gf_if.i_Level_Up && m_lives < 4) m_lives <= m_lives + 1;
                        if (m_shield > 0) m_shield <= m_shield - 1;
                    end
                end
                3: if (m_wait == 1) m_mode <= 4; else m_wait <= m_wait - 1;
                4: begin m_mode <= 2; m_shield <= SHIELD_LOAD; end
                5: if (m_wait == 1) m_mode <= 0; else m_wait <= m_wait - 1;
                default: m_mode <= 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("m_state",   int'(gf_if.o_State), m_mode);
        chk("m_lives",   int'(gf_if.o_Lives), therm(m_lives));
        chk("m_active",  int'(gf_if.o_Game_Active), (m_mode == 2) ? 1 : 0);
        chk("m_freeze",  int'(gf_if.o_Obstacles_Freeze),
            (m_mode == 0 || m_mode == 1 || m_mode == 3 || m_mode == 5) ? 1 : 0);
        chk("m_respawn", int'(gf_if.o_Frog_Respawn), (m_mode == 4) ? 1 : 0);
        chk("m_over",    int'(gf_if.o_Game_Over), (m_mode == 5) ? 1 : 0);
        chk("m_invuln",  int'(gf_if.o_Invulnerable), (m_shield > 0) ? 1 : 0);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input string name, input int exp, input int max_cyc);
        int n = 0;
        while (int'(gf_if.o_State) != exp && n < max_cyc) begin
            step();
            n++;
        end
        chk(name, int'(gf_if.o_State), exp);
    endtask

    task automatic wait_vulnerable();
        int n = 0;
        while (gf_if.o_Invulnerable && n < 10) begin
            step();
            n++;
        end
        chk("shield_drop", int'(gf_if.o_Invulnerable), 0);
    endtask

    task automatic hit_once();
        wait_vulnerable();
        gf_if.i_Has_Collided = 1'b1;
        step();
        gf_if.i_Has_Collided = 1'b0;
        chk("hit_once_state", int'(gf_if.o_State), 3);
        wait_state("hit_once_back", 2, 12);
    endtask

    initial begin
        int n;
        gf_if.i_Start        = 1'b0;
        gf_if.i_Has_Collided = 1'b0;
        gf_if.i_Level_Up     = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        step();
        step();
        // Reset state
        chk("rst_state",   int'(gf_if.o_State), 0);
        chk("rst_lives",   int'(gf_if.o_Lives), 15);
        chk("rst_freeze",  int'(gf_if.o_Obstacles_Freeze), 1);
        chk("rst_active",  int'(gf_if.o_Game_Active), 0);
        chk("rst_respawn", int'(gf_if.o_Frog_Respawn), 0);
        rst = 1'b0;
        step();
        chk("idle_state", int'(gf_if.o_State), 0);

        // Start chord held, then released
        gf_if.i_Start = 1'b1;
        repeat (5) step();
        chk("arm_state", int'(gf_if.o_State), 1);
        gf_if.i_Start = 1'b0;
        step();
        chk("start_respawn", int'(gf_if.o_Frog_Respawn), 1);
        chk("start_rs_state", int'(gf_if.o_State), 4);
        step();
        chk("start_active", int'(gf_if.o_Game_Active), 1);
        chk("start_state", int'(gf_if.o_State), 2);
        chk("start_lives", int'(gf_if.o_Lives), 15);
        chk("start_rs_low", int'(gf_if.o_Frog_Respawn), 0);

        // Single hit with collision held across the freeze
        wait_vulnerable();
        gf_if.i_Has_Collided = 1'b1;
        step();
        chk("hit_state", int'(gf_if.o_State), 3);
        chk("hit_lives", int'(gf_if.o_Lives), 7);
        repeat (3) step();
        chk("hit_hold", int'(gf_if.o_State), 3);
        chk("hit_lives_once", int'(gf_if.o_Lives), 7);
        step();
        chk("hit_respawn", int'(gf_if.o_Frog_Respawn), 1);
        chk("hit_rs_state", int'(gf_if.o_State), 4);
        gf_if.i_Has_Collided = 1'b0;
        step();
        chk("hit_back", int'(gf_if.o_State), 2);
        chk("hit_back_lives", int'(gf_if.o_Lives), 7);

        // Level-up
        hit_once();
        chk("lives_0011", int'(gf_if.o_Lives), 3);
        gf_if.i_Level_Up = 1'b1;
        step();
        chk("lvl_0111", int'(gf_if.o_Lives), 7);
        step();
        chk("lvl_1111", int'(gf_if.o_Lives), 15);
        step();
        chk("lvl_sat", int'(gf_if.o_Lives), 15);
        gf_if.i_Level_Up = 1'b0;

        // Collision and level-up together: collision wins
        hit_once();
        chk("lives_0111", int'(gf_if.o_Lives), 7);
        wait_vulnerable();
        gf_if.i_Has_Collided = 1'b1;
        gf_if.i_Level_Up     = 1'b1;
        step();
        gf_if.i_Has_Collided = 1'b0;
        gf_if.i_Level_Up     = 1'b0;
        chk("both_state", int'(gf_if.o_State), 3);
        chk("both_lives", int'(gf_if.o_Lives), 3);
        wait_state("both_back", 2, 12);

        // Last lives down to game over
        hit_once();
        chk("lives_0001", int'(gf_if.o_Lives), 1);
        wait_vulnerable();
        gf_if.i_Has_Collided = 1'b1;
        step();
        gf_if.i_Has_Collided = 1'b0;
        chk("over_state", int'(gf_if.o_State), 5);
        chk("over_flag", int'(gf_if.o_Game_Over), 1);
        chk("over_lives", int'(gf_if.o_Lives), 0);
        n = 0;
        while (gf_if.o_Game_Over && n < 20) begin
            n++;
            step();
        end
        chk("over_len", n, OVER);
        chk("over_idle", int'(gf_if.o_State), 0);
        chk("over_freeze", int'(gf_if.o_Obstacles_Freeze), 1);
        chk("over_lives_hold", int'(gf_if.o_Lives), 0);
        // Collision ignored while idle
        gf_if.i_Has_Collided = 1'b1;
        step();
        gf_if.i_Has_Collided = 1'b0;
        chk("idle_ignore_hit", int'(gf_if.o_State), 0);

        // Restart, collision held from the first playing cycle
        gf_if.i_Start = 1'b1;
        step();
        chk("restart_arm", int'(gf_if.o_State), 1);
        chk("restart_lives", int'(gf_if.o_Lives), 15);
        gf_if.i_Start = 1'b0;
        step();
        chk("restart_respawn", int'(gf_if.o_Frog_Respawn), 1);
        gf_if.i_Has_Collided = 1'b1;
        step();
        chk("restart_run", int'(gf_if.o_State), 2);
        chk("restart_shield", int'(gf_if.o_Invulnerable), (SHIELD_LOAD > 0) ? 1 : 0);
        n = 0;
        while (int'(gf_if.o_State) != 3 && n < 10) begin
            step();
            n++;
        end
        chk("accept_delay", n, ACCEPT_N);

        // Asynchronous reset in the middle of a hit freeze
        step();
        gf_if.i_Has_Collided = 1'b0;
        chk("pre_reset_hit", int'(gf_if.o_State), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", int'(gf_if.o_State), 0);
        chk("arst_respawn", int'(gf_if.o_Frog_Respawn), 0);
        chk("arst_lives", int'(gf_if.o_Lives), 15);
        chk("arst_active", int'(gf_if.o_Game_Active), 0);
        chk("arst_freeze", int'(gf_if.o_Obstacles_Freeze), 1);
        step();
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            chk("post_rst_respawn", int'(gf_if.o_Frog_Respawn), 0);
            chk("post_rst_state", int'(gf_if.o_State), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
